// File: rtl/toggle_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : toggle_pkg
//  Description : Shared defaults and helpers for the toggle event decoder.
//                Holds the default lane count, the default counter width and
//                the depth of the optional input synchronizer.
//  Revision    : 1.0 - initial release
// ============================================================================
package toggle_pkg;

  // Default number of independent toggle lanes
  localparam int C_LANES_DEFAULT = 4;

  // Default width of each per-lane event counter
  localparam int C_CNT_W_DEFAULT = 8;

  // Number of flops in the optional per-lane input synchronizer
  localparam int C_SYNC_DEPTH = 2;

  // Width of a lane-select field; never collapses to zero bits
  function automatic int sel_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage : toggle_pkg
`default_nettype wire

// File: rtl/toggle_lane.sv
`default_nettype none
// ============================================================================
//  Module      : toggle_lane
//  Description : One toggle-encoded event lane. Optional 2-flop input
//                synchronizer (macro TOGGLE_INPUT_SYNC_EN), r1/r2 edge
//                detector, registered one-cycle pulse, wrapping event
//                counter, sticky and overflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module toggle_lane
  import toggle_pkg::*;
#(
  parameter int CNT_W = C_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             arm_i,
  input  logic             clr_i,
  input  logic             t_i,
  output logic             pulse_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sticky_o,
  output logic             ovf_o
);

  logic             w_in;
  logic             w_event;
  logic             w_rec;

  logic             r1_q, r1_d;
  logic             r2_q, r2_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic             ovf_q, ovf_d;

`ifdef TOGGLE_INPUT_SYNC_EN
  logic [C_SYNC_DEPTH-1:0] sync_q;

  // Shift the raw toggle level through the synchronizer chain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[C_SYNC_DEPTH-2:0], t_i};
    end
  end

  assign w_in = sync_q[C_SYNC_DEPTH-1];
`else
  assign w_in = t_i;
`endif

  // A level difference between r1 and r2 is exactly one toggle event
  assign w_event = r1_q ^ r2_q;
  assign w_rec   = arm_i & w_event;

  // Next-state: edge detector, pulse, and clear-then-record bookkeeping
  always_comb begin
    r1_d     = r1_q;
    r2_d     = r2_q;
    pulse_d  = 1'b0;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    ovf_d    = ovf_q;

    if (load_i) begin
      // Baseline both stages on the current level so no spurious event
      r1_d = w_in;
      r2_d = w_in;
    end else if (arm_i) begin
      r1_d    = w_in;
      r2_d    = r1_q;
      pulse_d = w_event;
    end

    if (clr_i) begin
      cnt_d    = w_rec ? CNT_W'(1) : '0;
      sticky_d = w_rec;
      ovf_d    = 1'b0;
    end else if (w_rec) begin
      cnt_d    = cnt_q + CNT_W'(1);
      sticky_d = 1'b1;
      if (cnt_q == {CNT_W{1'b1}}) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Lane state registers, cleared immediately on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1_q     <= 1'b0;
      r2_q     <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      r1_q     <= r1_d;
      r2_q     <= r2_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
    end
  end

  assign pulse_o  = pulse_q;
  assign cnt_o    = cnt_q;
  assign sticky_o = sticky_q;
  assign ovf_o    = ovf_q;

endmodule : toggle_lane
`default_nettype wire

// File: rtl/toggle_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : toggle_event_decoder
//  Description : Decodes LANES toggle-encoded event lines into one-cycle
//                pulses with per-lane counters, sticky and overflow flags.
//                Holds the post-reset arm sequencing, clr fan-out and the
//                counter read mux. Define TOGGLE_INPUT_SYNC_EN to insert a
//                2-flop synchronizer per lane ahead of the edge detector.
//  Revision    : 1.0 - initial release
// ============================================================================
module toggle_event_decoder
  import toggle_pkg::*;
#(
  parameter int LANES = C_LANES_DEFAULT,
  parameter int CNT_W = C_CNT_W_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LANES-1:0]            t_in,
  input  logic                        clr,
  input  logic [sel_width(LANES)-1:0] cnt_sel,
  output logic [LANES-1:0]            pulse_out,
  output logic [CNT_W-1:0]            cnt_out,
  output logic [LANES-1:0]            sticky,
  output logic [LANES-1:0]            overflow
);

  localparam int SEL_W = sel_width(LANES);

  // Edges to wait after reset release before the lanes take their baseline
`ifdef TOGGLE_INPUT_SYNC_EN
  localparam logic [1:0] C_ARM_WAIT = 2'(C_SYNC_DEPTH);
`else
  localparam logic [1:0] C_ARM_WAIT = 2'd0;
`endif

  logic             arm_q, arm_d;
  logic [1:0]       settle_q, settle_d;
  logic             w_load;
  logic [CNT_W-1:0] w_lane_cnt [LANES];

  // Arm sequencing: wait for the input path to settle, then baseline once
  always_comb begin
    arm_d    = arm_q;
    settle_d = settle_q;
    w_load   = 1'b0;
    if (!arm_q) begin
      if (settle_q == C_ARM_WAIT) begin
        w_load = 1'b1;
        arm_d  = 1'b1;
      end else begin
        settle_d = settle_q + 2'd1;
      end
    end
  end

  // Arm state registers, cleared immediately on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arm_q    <= 1'b0;
      settle_q <= 2'd0;
    end else begin
      arm_q    <= arm_d;
      settle_q <= settle_d;
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      toggle_lane #(
        .CNT_W (CNT_W)
      ) u_lane (
        .clk      (clk),
        .rst      (rst),
        .load_i   (w_load),
        .arm_i    (arm_q),
        .clr_i    (clr),
        .t_i      (t_in[gi]),
        .pulse_o  (pulse_out[gi]),
        .cnt_o    (w_lane_cnt[gi]),
        .sticky_o (sticky[gi]),
        .ovf_o    (overflow[gi])
      );
    end
  endgenerate

  // Read mux; selects that match no lane return zero
  always_comb begin
    cnt_out = '0;
    for (int i = 0; i < LANES; i++) begin
      if (cnt_sel == SEL_W'(i)) begin
        cnt_out = w_lane_cnt[i];
      end
    end
  end

endmodule : toggle_event_decoder
`default_nettype wire
